// File: rtl/async_ram_16_8.sv
// Small register-file RAM: one write port, one registered read port, one clock.
// A synchronous clear zeroes every word and the read register together.
module async_ram_16_8 #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int RD_FIRST = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              re,
   input  logic              we,
   input  logic [ADDR_W-1:0] rd_add,
   input  logic [ADDR_W-1:0] wr_add,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Port protocol: no handshake. we/re are single-cycle enables sampled on
   // the rising edge; read data appears on d_out one cycle after re and is
   // held while re stays low. clr overrides both enables on its edge.

   logic [DATA_W-1:0] mem [DEPTH];
   logic              same_addr_hit;

   // A same-edge read of the word being written returns the new data only
   // in write-first mode; read-first simply returns the stored word.
   assign same_addr_hit = (RD_FIRST == 0) && we && (wr_add == rd_add);

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         d_out <= '0;
      end else begin
         if (we) begin
            mem[wr_add] <= d_in;
         end
         if (re) begin
            if (same_addr_hit) begin
               d_out <= d_in;
            end else begin
               d_out <= mem[rd_add];
            end
         end
      end
   end

endmodule

// File: tb/tb_async_ram_16_8.sv
// Directed bench for async_ram_16_8 (write-first build): clear, fill/readback,
// collisions, hold with re low, clear overriding a write, boundary addresses.
module tb_async_ram_16_8;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;

   logic              clk;
   logic              clr;
   logic              re;
   logic              we;
   logic [ADDR_W-1:0] rd_add;
   logic [ADDR_W-1:0] wr_add;
   logic [DATA_W-1:0] d_in;
   logic [DATA_W-1:0] d_out;

   int assertions_evaluated = 0;
   int failures = 0;
   logic [DATA_W-1:0] exp_q[$];

   async_ram_16_8 #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .RD_FIRST(0)
   ) dut (
      .clk   (clk),
      .clr   (clr),
      .re    (re),
      .we    (we),
      .rd_add(rd_add),
      .wr_add(wr_add),
      .d_in  (d_in),
      .d_out (d_out)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      assertions_evaluated++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      we = 1'b1; wr_add = a; d_in = d;
      tick();
      we = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] exp);
      exp_q.push_back(exp);
      re = 1'b1; rd_add = a;
      tick();
      re = 1'b0;
      check(tag, d_out, exp_q.pop_front());
   endtask

   initial begin
      clr = 1'b0; re = 1'b0; we = 1'b0;
      rd_add = '0; wr_add = '0; d_in = '0;
      #2;

      // 1: clear for 5 cycles, everything reads 0
      clr = 1'b1;
      repeat (5) tick();
      clr = 1'b0;
      check("reset_d_out", d_out, 16'h0000);
      for (int i = 0; i < 8; i++) do_read($sformatf("clr_rd%0d", i), ADDR_W'(i), 16'h0000);

      // 2: fill with i+3, read back
      for (int i = 0; i < 8; i++) do_write(ADDR_W'(i), DATA_W'(i + 3));
      for (int i = 0; i < 8; i++) do_read($sformatf("fill_rd%0d", i), ADDR_W'(i), DATA_W'(i + 3));

      // 3: same-address collision bypasses new data; stored value follows
      we = 1'b1; wr_add = 3'd5; d_in = 16'hBEEF;
      re = 1'b1; rd_add = 3'd5;
      tick();
      we = 1'b0; re = 1'b0;
      check("collide_same", d_out, 16'hBEEF);
      do_read("collide_after", 3'd5, 16'hBEEF);

      // different addresses on the same edge both complete
      we = 1'b1; wr_add = 3'd6; d_in = 16'h1111;
      re = 1'b1; rd_add = 3'd3;
      tick();
      we = 1'b0; re = 1'b0;
      check("collide_diff_rd", d_out, 16'h0006);
      do_read("collide_diff_wr", 3'd6, 16'h1111);

      // 4: d_out holds with re low, then returns the new word
      do_write(3'd2, 16'hA5A5);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("hold%0d", i), d_out, 16'h1111);
      end
      do_read("hold_then_rd2", 3'd2, 16'hA5A5);

      // 5: clr overrides write and read on the same edge
      clr = 1'b1;
      we = 1'b1; wr_add = 3'd1; d_in = 16'h1234;
      re = 1'b1; rd_add = 3'd2;
      tick();
      clr = 1'b0; we = 1'b0; re = 1'b0;
      check("clr_pulse_d_out", d_out, 16'h0000);
      for (int i = 0; i < 8; i++) do_read($sformatf("clr2_rd%0d", i), ADDR_W'(i), 16'h0000);

      // 6: boundary addresses, full-width data
      do_write(3'd7, 16'hFFFF);
      do_write(3'd0, 16'h0001);
      do_read("bound_rd7", 3'd7, 16'hFFFF);
      do_read("bound_rd0", 3'd0, 16'h0001);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures",
               assertions_evaluated, failures);
      $finish;
   end

endmodule
